// File: rtl/sched_ctrl.sv
// Schedule controller for the shared ALU / MUL / LOGIC datapath computing
// (i1*i2*(i5+i6))*(i3*i4) - ((i1*i2)^(i5+i6)); Moore FSM with start/stall.
module sched_ctrl #(
  parameter logic [3:0] IDLE_SEL = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  output logic [3:0] alu1_sel1,
  output logic [3:0] alu1_sel2,
  output logic       alu1_op,
  output logic [3:0] mul1_sel1,
  output logic [3:0] mul1_sel2,
  output logic       mul1_op,
  output logic [3:0] log1_sel1,
  output logic [3:0] log1_sel2,
  output logic [1:0] log1_op,
  output logic       reg_mul2_en,
  output logic       reg_mul5_en,
  output logic       reg_alu6_en,
  output logic       reg_mul7_en,
  output logic       reg_mul10_en,
  output logic       reg_log11_en,
  output logic       reg_alu12_en,
  output logic       result_en,
  output logic       done_next,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, OUT} state_t;

  state_t state;
  logic   wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !stall) state <= S1;
        S1:      if (!stall) state <= S2;
        S2:      if (!stall) state <= S3;
        S3:      if (!stall) state <= S4;
        S4:      if (!stall) state <= S5;
        S5:      if (!stall) state <= OUT;
        OUT:     if (!stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Selects/ops follow the state even while stalled; only writes are gated.
  assign wr = !stall;

  always_comb begin
    alu1_sel1    = IDLE_SEL;
    alu1_sel2    = IDLE_SEL;
    alu1_op      = 1'b0;
    mul1_sel1    = IDLE_SEL;
    mul1_sel2    = IDLE_SEL;
    mul1_op      = 1'b0;
    log1_sel1    = IDLE_SEL;
    log1_sel2    = IDLE_SEL;
    log1_op      = 2'b00;
    reg_mul2_en  = 1'b0;
    reg_mul5_en  = 1'b0;
    reg_alu6_en  = 1'b0;
    reg_mul7_en  = 1'b0;
    reg_mul10_en = 1'b0;
    reg_log11_en = 1'b0;
    reg_alu12_en = 1'b0;
    result_en    = 1'b0;
    done_next    = 1'b0;
    busy         = (state != IDLE);
    case (state)
      S1: begin
        mul1_sel1   = 4'd0;
        mul1_sel2   = 4'd1;
        reg_mul2_en = wr;
      end
      S2: begin
        mul1_sel1   = 4'd2;
        mul1_sel2   = 4'd3;
        reg_mul5_en = wr;
        alu1_sel1   = 4'd4;
        alu1_sel2   = 4'd5;
        reg_alu6_en = wr;
      end
      S3: begin
        mul1_sel1   = 4'd6;
        mul1_sel2   = 4'd8;
        reg_mul7_en = wr;
      end
      S4: begin
        mul1_sel1    = 4'd9;
        mul1_sel2    = 4'd7;
        reg_mul10_en = wr;
        log1_sel1    = 4'd6;
        log1_sel2    = 4'd8;
        log1_op      = 2'b10;
        reg_log11_en = wr;
      end
      S5: begin
        alu1_sel1    = 4'd10;
        alu1_sel2    = 4'd11;
        alu1_op      = 1'b1;
        reg_alu12_en = wr;
      end
      OUT: begin
        result_en = wr;
        done_next = wr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sched_ctrl.sv
// Bench for sched_ctrl: a behavioural datapath driven by the controller, a
// cycle-phase model of the schedule, and directed plus randomized operations.
module tb_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stall;
  logic [3:0] alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2, log1_sel1, log1_sel2;
  logic       alu1_op, mul1_op;
  logic [1:0] log1_op;
  logic       reg_mul2_en, reg_mul5_en, reg_alu6_en, reg_mul7_en, reg_mul10_en;
  logic       reg_log11_en, reg_alu12_en, result_en, done_next, busy;

  int checks = 0;
  int errors = 0;

  sched_ctrl #(.IDLE_SEL(4'd15)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .alu1_sel1(alu1_sel1), .alu1_sel2(alu1_sel2), .alu1_op(alu1_op),
    .mul1_sel1(mul1_sel1), .mul1_sel2(mul1_sel2), .mul1_op(mul1_op),
    .log1_sel1(log1_sel1), .log1_sel2(log1_sel2), .log1_op(log1_op),
    .reg_mul2_en(reg_mul2_en), .reg_mul5_en(reg_mul5_en), .reg_alu6_en(reg_alu6_en),
    .reg_mul7_en(reg_mul7_en), .reg_mul10_en(reg_mul10_en), .reg_log11_en(reg_log11_en),
    .reg_alu12_en(reg_alu12_en), .result_en(result_en), .done_next(done_next), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural datapath ----------------
  logic [31:0] in_v [6];
  logic [31:0] dreg [13];
  logic [31:0] result;
  logic        done;
  int          done_cnt = 0;

  function automatic logic [31:0] opnd(input logic [3:0] s);
    if (s < 4'd6)       return in_v[s];
    else if (s < 4'd13) return dreg[s];
    else                return 32'd0;
  endfunction

  logic [31:0] mul_r, alu_r, log_r;
  always_comb begin
    mul_r = mul1_op ? 32'd0 : opnd(mul1_sel1) * opnd(mul1_sel2);
    alu_r = alu1_op ? opnd(alu1_sel1) - opnd(alu1_sel2) : opnd(alu1_sel1) + opnd(alu1_sel2);
    case (log1_op)
      2'b00:   log_r = opnd(log1_sel1) & opnd(log1_sel2);
      2'b01:   log_r = opnd(log1_sel1) | opnd(log1_sel2);
      default: log_r = opnd(log1_sel1) ^ opnd(log1_sel2);
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 13; k++) dreg[k] <= 32'd0;
      result <= 32'd0;
      done   <= 1'b0;
    end else begin
      if (reg_mul2_en)  dreg[6]  <= mul_r;
      if (reg_mul5_en)  dreg[7]  <= mul_r;
      if (reg_alu6_en)  dreg[8]  <= alu_r;
      if (reg_mul7_en)  dreg[9]  <= mul_r;
      if (reg_mul10_en) dreg[10] <= mul_r;
      if (reg_log11_en) dreg[11] <= log_r;
      if (reg_alu12_en) dreg[12] <= alu_r;
      if (result_en)    result   <= dreg[12];
      done <= done_next;
      if (done_next) done_cnt <= done_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  // ph = cycles into the current operation (0 idle, 1..5 compute, 6 output).
  int ph = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) ph <= 0;
    else if (!stall) begin
      if (ph == 0) ph <= start ? 1 : 0;
      else if (ph == 6) ph <= 0;
      else ph <= ph + 1;
    end
  end

  function automatic logic [8:0] exp_en(input int p);
    case (p)
      1:       return 9'b100000000;
      2:       return 9'b011000000;
      3:       return 9'b000100000;
      4:       return 9'b000011000;
      5:       return 9'b000000100;
      6:       return 9'b000000011;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    return (in_v[0] * in_v[1] * (in_v[4] + in_v[5])) * (in_v[2] * in_v[3])
           - ((in_v[0] * in_v[1]) ^ (in_v[4] + in_v[5]));
  endfunction

  logic [8:0] en_vec;
  assign en_vec = {reg_mul2_en, reg_mul5_en, reg_alu6_en, reg_mul7_en, reg_mul10_en,
                   reg_log11_en, reg_alu12_en, result_en, done_next};

  // Per-cycle check of enables, busy and idle-FU defaults.
  always @(negedge clk) begin
    logic alu_idle, log_idle, mul_idle;
    alu_idle = (ph != 2 && ph != 5);
    log_idle = (ph != 4);
    mul_idle = (ph == 0 || ph >= 5);
    checks++;
    assert (busy === (ph != 0)) else begin
      errors++; $error("FAIL busy ph=%0d got=%b exp=%b", ph, busy, ph != 0);
    end
    checks++;
    assert (en_vec === (stall ? 9'd0 : exp_en(ph))) else begin
      errors++; $error("FAIL en ph=%0d stall=%b got=%b exp=%b", ph, stall, en_vec,
                       stall ? 9'd0 : exp_en(ph));
    end
    checks++;
    assert (mul1_op === 1'b0 &&
            (!alu_idle || {alu1_sel1, alu1_sel2, alu1_op} === 9'h1FE) &&
            (!log_idle || {log1_sel1, log1_sel2, log1_op} === 10'h3FC) &&
            (!mul_idle || {mul1_sel1, mul1_sel2} === 8'hFF)) else begin
      errors++; $error("FAIL defaults ph=%0d got alu=%h/%h/%b mul=%h/%h/%b log=%h/%h/%b exp idle=15 op=0",
                       ph, alu1_sel1, alu1_sel2, alu1_op, mul1_sel1, mul1_sel2, mul1_op,
                       log1_sel1, log1_sel2, log1_op);
    end
  end

  // ---------------- stimulus ----------------
  // mode: 0 none, 1 stall st_n cycles at phase 3, 2 random stalls, 3 re-start at phase 2
  task automatic run_op(input int mode, input int st_n, input string tag);
    int cyc, lat, nst, left, d0;
    bit seen;
    nst = 0; left = st_n; seen = 0; lat = -1; d0 = done_cnt;
    @(negedge clk); start = 1'b1; stall = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (done) begin lat = cyc; seen = 1; break; end
      @(negedge clk);
      start = (mode == 3 && ph == 2);
      stall = 1'b0;
      if (mode == 1 && ph == 3 && left > 0) begin stall = 1'b1; left--; nst++; end
      if (mode == 2 && ph != 0 && $urandom_range(3) == 0) begin stall = 1'b1; nst++; end
    end
    @(negedge clk); start = 1'b0; stall = 1'b0;
    checks++;
    assert (seen && lat == 6 + nst) else begin
      errors++; $error("FAIL %s latency got=%0d exp=%0d", tag, lat, 6 + nst);
    end
    checks++;
    assert (result === ref_result()) else begin
      errors++; $error("FAIL %s result got=%0d exp=%0d", tag, result, ref_result());
    end
    repeat (9) @(negedge clk);
    checks++;
    assert (done_cnt - d0 == 1) else begin
      errors++; $error("FAIL %s done_count got=%0d exp=1", tag, done_cnt - d0);
    end
  endtask

  task automatic set_in(input int a, b, c, d, e, f);
    in_v[0] = a; in_v[1] = b; in_v[2] = c; in_v[3] = d; in_v[4] = e; in_v[5] = f;
  endtask

  initial begin
    int d1, d2, c;
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    set_in(3, 4, 5, 6, 7, 8);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    assert (done_cnt == 0 && {alu1_sel1, mul1_sel1, log1_sel1} === 12'hFFF) else begin
      errors++; $error("FAIL idle got done_cnt=%0d sels=%h exp=0/fff", done_cnt,
                       {alu1_sel1, mul1_sel1, log1_sel1});
    end

    // start with stall in IDLE must not be accepted
    start = 1'b1; stall = 1'b1;
    @(negedge clk); start = 1'b0; stall = 1'b0;
    @(negedge clk);
    checks++;
    assert (busy === 1'b0) else begin
      errors++; $error("FAIL start_stall busy got=%b exp=0", busy);
    end

    run_op(0, 0, "basic");
    checks++;
    assert (dreg[6] === 32'd12 && dreg[7] === 32'd30 && dreg[8] === 32'd15 &&
            dreg[9] === 32'd180 && dreg[10] === 32'd5400 && dreg[11] === 32'd3 &&
            result === 32'd5397) else begin
      errors++; $error("FAIL intermediates got=%0d,%0d,%0d,%0d,%0d,%0d,%0d exp=12,30,15,180,5400,3,5397",
                       dreg[6], dreg[7], dreg[8], dreg[9], dreg[10], dreg[11], result);
    end
    run_op(1, 3, "stall_s3");
    run_op(3, 0, "restart_busy");

    // back-to-back with start held high
    set_in(2, 1, 1, 1, 1, 1);
    d1 = -1; d2 = -1;
    @(negedge clk); start = 1'b1;
    for (c = 0; c < 40 && d2 < 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        checks++;
        assert (result === ref_result()) else begin
          errors++; $error("FAIL b2b result got=%0d exp=%0d", result, ref_result());
        end
        if (d1 < 0) d1 = c; else d2 = c;
      end
    end
    @(negedge clk); start = 1'b0;
    checks++;
    assert (d1 == 6 && d2 == 13) else begin
      errors++; $error("FAIL b2b timing got=%0d/%0d exp=6/13", d1, d2);
    end
    repeat (10) @(negedge clk);

    // asynchronous reset in S4
    set_in(3, 4, 5, 6, 7, 8);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (c = 0; c < 10 && ph != 4; c++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    assert (ph == 0 && busy === 1'b0 && en_vec === 9'd0) else begin
      errors++; $error("FAIL async_rst got busy=%b en=%b exp=0/0", busy, en_vec);
    end
    @(negedge clk); rst = 1'b0;
    run_op(0, 0, "after_rst");

    // randomized operands and stalls
    for (int n = 0; n < 20; n++) begin
      set_in($urandom_range(31), $urandom_range(31), $urandom_range(31),
             $urandom_range(31), $urandom_range(31), $urandom_range(31));
      run_op(2, 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
